// File: rtl/mmsa_pkg.sv
// Shared types and constants for the MMSA result packer.
// Size codes, frame-length lookup, result width and 32-bit clamp bounds.
package mmsa_pkg;

  localparam int RES_W = 40;

  typedef enum logic [1:0] {
    SZ_2X2   = 2'd0,
    SZ_4X4   = 2'd1,
    SZ_8X8   = 2'd2,
    SZ_16X16 = 2'd3
  } size_e;

  localparam logic signed [RES_W-1:0] SAT_MAX = 40'sh007FFFFFFF;
  localparam logic signed [RES_W-1:0] SAT_MIN = 40'shFF80000000;

  // An NxN array emits 2N-1 result words per frame.
  function automatic logic [4:0] frame_len(size_e s);
    logic [4:0] len;
    len = 5'd31;
    unique case (s)
      SZ_2X2:   len = 5'd3;
      SZ_4X4:   len = 5'd7;
      SZ_8X8:   len = 5'd15;
      SZ_16X16: len = 5'd31;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/mmsa_result_packer_if.sv
// Output stream of the result packer: valid/ready word with last and sat flags.
// master drives o_valid/o_data/o_last/o_sat, slave drives o_ready.
interface mmsa_result_packer_if;
  import mmsa_pkg::*;

  logic             o_valid;
  logic             o_ready;
  logic [RES_W-1:0] o_data;
  logic             o_last;
  logic             o_sat;

  modport master (
    output o_valid,
    output o_data,
    output o_last,
    output o_sat,
    input  o_ready
  );

  modport slave (
    input  o_valid,
    input  o_data,
    input  o_last,
    input  o_sat,
    output o_ready
  );

endinterface

// File: rtl/mmsa_res_fifo.sv
// Result FIFO: W-bit entries, DEPTH deep, occupancy counter for full/empty.
// Ports: clk, rst, push/wdata, pop/rdata, valid (not empty), full.
module mmsa_res_fifo #(
  parameter int W     = 42,
  parameter int DEPTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         valid,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [OW-1:0] occ;
  logic          do_push;
  logic          do_pop;

  assign valid   = (occ != '0);
  assign full    = (occ == OW'(DEPTH));
  assign do_pop  = pop && valid;
  // A full FIFO still accepts a word when the head leaves this cycle.
  assign do_push = push && (!full || do_pop);
  // Empty reads as zero so the output word is 0 out of reset.
  assign rdata   = valid ? mem[rptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/mmsa_result_packer.sv
// Frames systolic-array results, tags the last word, buffers them in a FIFO.
// Ports: clk, rst, cfg_valid/cfg_size, in_valid/in_value, out (stream), err_ovf.
// Macro MMSA_RESULT_SAT_EN: clamp each word to signed 32-bit and flag o_sat.
module mmsa_result_packer
  import mmsa_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  input  logic [1:0]              cfg_size,
  input  logic                    in_valid,
  input  logic signed [RES_W-1:0] in_value,
  mmsa_result_packer_if.master    out,
  output logic                    err_ovf
);

  localparam int FW = RES_W + 2;

  size_e            size_q;
  size_e            size_cur;
  logic [4:0]       cnt;
  logic [4:0]       len;
  logic             is_last;
  logic             at_start;
  logic [RES_W-1:0] word;
  logic             sat;
  logic [FW-1:0]    wdata;
  logic [FW-1:0]    rdata;
  logic             fifo_valid;
  logic             fifo_full;
  logic             pop;

  assign at_start = (cnt == '0);

  // A size change takes effect only on a frame boundary, including the
  // word arriving in the same cycle as the config pulse.
  always_comb begin
    size_cur = size_q;
    if (cfg_valid && at_start) begin
      size_cur = size_e'(cfg_size);
    end
  end

  assign len     = frame_len(size_cur);
  assign is_last = (cnt == len - 5'd1);

`ifdef MMSA_RESULT_SAT_EN
  always_comb begin
    word = in_value;
    sat  = 1'b0;
    if (in_value > SAT_MAX) begin
      word = SAT_MAX;
      sat  = 1'b1;
    end else if (in_value < SAT_MIN) begin
      word = SAT_MIN;
      sat  = 1'b1;
    end
  end
`else
  assign word = in_value;
  assign sat  = 1'b0;
`endif

  assign wdata = {sat, is_last, word};
  assign pop   = fifo_valid && out.o_ready;

  mmsa_res_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .valid (fifo_valid),
    .full  (fifo_full)
  );

  assign out.o_valid = fifo_valid;
  assign out.o_data  = rdata[RES_W-1:0];
  assign out.o_last  = rdata[RES_W];
  assign out.o_sat   = rdata[RES_W+1];

  // The counter advances on every strobe, dropped or not, so a lost word
  // never shifts the last-word position of later frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      size_q  <= SZ_16X16;
      err_ovf <= 1'b0;
    end else begin
      if (cfg_valid && at_start) begin
        size_q <= size_e'(cfg_size);
      end
      if (in_valid) begin
        cnt <= is_last ? 5'd0 : cnt + 5'd1;
      end
      if (in_valid && fifo_full && !pop) begin
        err_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mmsa_result_packer.sv
// Scoreboard bench for mmsa_result_packer: queue model, negedge monitor.
// Directed frame scenarios followed by randomized traffic and resets.
module tb_mmsa_result_packer;

  localparam int DEPTH = 32;

  typedef struct packed {
    logic [39:0] d;
    logic        l;
    logic        s;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic [1:0]  cfg_size;
  logic        in_valid;
  logic [39:0] in_value;
  logic        err_ovf;

  mmsa_result_packer_if ob ();

  mmsa_result_packer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_size  (cfg_size),
    .in_valid  (in_valid),
    .in_value  (in_value),
    .out       (ob),
    .err_ovf   (err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   inflight    = 0;
  bit   pend_drop   = 0;
  bit   err_exp     = 0;
  bit   mon_en      = 0;
  int   pos         = 0;
  int   msize       = 3;

  always @(negedge clk) begin
    exp_t e;
    bit   ev;
    if (mon_en) begin
      ev = (exp_q.size() - inflight) > 0;
      vectors++;
      if (ob.o_valid !== ev) begin
        miscompares++;
        $display("FAIL o_valid got %0b want %0b t=%0t", ob.o_valid, ev, $time);
      end
      vectors++;
      if (err_ovf !== err_exp) begin
        miscompares++;
        $display("FAIL err_ovf got %0b want %0b t=%0t", err_ovf, err_exp, $time);
      end
      if (ob.o_valid && ob.o_ready) begin
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL pop_unexpected data %0d t=%0t", $signed(ob.o_data), $time);
        end else begin
          e = exp_q.pop_front();
          vectors++;
          if ({ob.o_data, ob.o_last, ob.o_sat} !== {e.d, e.l, e.s}) begin
            miscompares++;
            $display("FAIL word got d=%0d l=%0b s=%0b want d=%0d l=%0b s=%0b t=%0t",
                     $signed(ob.o_data), ob.o_last, ob.o_sat,
                     $signed(e.d), e.l, e.s, $time);
          end
        end
      end
    end
  end

  task automatic chk(string name, logic [39:0] got, logic [39:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  function automatic exp_t model_word(logic [39:0] v, bit lst);
    exp_t e;
    e.d = v;
    e.l = lst;
    e.s = 1'b0;
`ifdef MMSA_RESULT_SAT_EN
    begin
      longint lv;
      lv = $signed(v);
      if (lv > 64'sd2147483647) begin
        e.d = 40'(64'sd2147483647);
        e.s = 1'b1;
      end else if (lv < -64'sd2147483648) begin
        e.d = 40'(-64'sd2147483648);
        e.s = 1'b1;
      end
    end
`endif
    return e;
  endfunction

  task automatic step(bit iv, logic [39:0] v, bit cv, logic [1:0] cs, bit rdy);
    int len;
    bit lst;
    err_exp  |= pend_drop;
    pend_drop = 0;
    inflight  = 0;
    in_valid  = iv;
    in_value  = v;
    cfg_valid = cv;
    cfg_size  = cs;
    o_ready_drive(rdy);
    if (cv && pos == 0) msize = int'(cs);
    if (iv) begin
      len = (4 << msize) - 1;
      lst = (pos == len - 1);
      pos = lst ? 0 : pos + 1;
      if (exp_q.size() >= DEPTH && !rdy) begin
        pend_drop = 1;
      end else begin
        exp_q.push_back(model_word(v, lst));
        inflight = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic o_ready_drive(bit rdy);
    ob.o_ready = rdy;
  endtask

  task automatic do_reset;
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    err_exp  |= pend_drop;
    pend_drop = 0;
    inflight  = 0;
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_value  = r[39:0];
    cfg_valid = 1'b0;
    cfg_size  = 2'd0;
    ob.o_ready = 1'b0;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    pos     = 0;
    msize   = 3;
    err_exp = 0;
    mon_en  = 1;
    chk("rst_o_valid", {39'd0, ob.o_valid}, 40'd0);
    chk("rst_o_data", ob.o_data, 40'd0);
    chk("rst_o_last", {39'd0, ob.o_last}, 40'd0);
    chk("rst_o_sat", {39'd0, ob.o_sat}, 40'd0);
    chk("rst_err_ovf", {39'd0, err_ovf}, 40'd0);
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      step(0, '0, 0, 2'd0, 1);
      n++;
    end
    vectors++;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain_timeout left %0d words", exp_q.size());
    end
  endtask

  function automatic logic [39:0] rnd_val();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    if ($urandom_range(0, 1) == 0) return {{24{r[15]}}, r[15:0]};
    return r[39:0];
  endfunction

  initial begin
    rst = 1'b0;
    cfg_valid = 1'b0;
    cfg_size = 2'd0;
    in_valid = 1'b0;
    in_value = '0;
    ob.o_ready = 1'b0;
    do_reset();

    // 2x2 frame, streaming through
    step(0, '0, 1, 2'd0, 1);
    step(1, 40'd5, 0, 2'd0, 1);
    step(1, -40'sd7, 0, 2'd0, 1);
    step(1, 40'd9, 0, 2'd0, 1);
    drain();

    // 16x16 frame buffered, then drained
    step(0, '0, 1, 2'd3, 0);
    for (int i = 0; i < 31; i++) step(1, 40'(i + 100), 0, 2'd0, 0);
    drain();

    // overflow: fill, drop one, finish frame with ready high
    for (int i = 0; i < 31; i++) step(1, 40'(i + 200), 0, 2'd0, 0);
    step(1, 40'd300, 0, 2'd0, 0);
    step(1, 40'd301, 0, 2'd0, 0);
    for (int i = 0; i < 29; i++) step(1, 40'(i + 302), 0, 2'd0, 1);
    drain();

    // mid-frame config ignored
    do_reset();
    step(1, 40'd1, 0, 2'd0, 1);
    step(1, 40'd2, 0, 2'd0, 1);
    step(0, '0, 1, 2'd1, 1);
    for (int i = 2; i < 62; i++) step(1, 40'(i + 1), 0, 2'd0, 1);
    drain();

    // config and word together on a frame boundary
    step(1, 40'd77, 1, 2'd0, 1);
    step(1, 40'd78, 0, 2'd0, 1);
    step(1, 40'd79, 0, 2'd0, 1);
    drain();

    // large values
    step(1, 40'sh0800000000, 0, 2'd0, 1);
    step(1, -40'sh0800000000, 0, 2'd0, 1);
    step(1, 40'sh007FFFFFFF, 0, 2'd0, 1);
    drain();

    // reset mid 4x4 frame
    do_reset();
    step(0, '0, 1, 2'd1, 0);
    for (int i = 0; i < 4; i++) step(1, 40'(i + 1), 0, 2'd0, 0);
    do_reset();
    for (int i = 0; i < 31; i++) step(1, 40'(i + 500), 0, 2'd0, 1);
    drain();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) < 3) begin
        do_reset();
      end else begin
        step($urandom_range(0, 99) < 60, rnd_val(),
             $urandom_range(0, 99) < 5, 2'($urandom_range(0, 3)),
             $urandom_range(0, 99) < 50);
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
